// File: rtl/i2c_pkg.sv
// Shared I2C definitions: engine op-codes, sequencer state encoding,
// byte width.
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;

    typedef logic [1:0] i2c_op_t;

    localparam i2c_op_t I2C_OP_START = 2'd0;
    localparam i2c_op_t I2C_OP_WRITE = 2'd1;
    localparam i2c_op_t I2C_OP_READ  = 2'd2;
    localparam i2c_op_t I2C_OP_STOP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_STOP,
        ST_DONE
    } i2c_state_e;

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// Request/stream/status and engine command/response bundle of the
// I2C transaction sequencer.
interface i2c_txn_sequencer_if #(parameter int LEN_W = 8);
    import i2c_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [6:0]            req_addr;
    logic [LEN_W-1:0]      req_len;
    logic [I2C_BYTE_W-1:0] wr_data;
    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic [I2C_BYTE_W-1:0] rd_data;
    logic                  rd_data_valid;
    logic                  done;
    logic                  nack_err;
    logic                  busy;
    logic                  core_cmd_valid;
    logic                  core_cmd_ready;
    i2c_op_t               core_cmd_op;
    logic [I2C_BYTE_W-1:0] core_cmd_wdata;
    logic                  core_cmd_last;
    logic                  core_rsp_valid;
    logic [I2C_BYTE_W-1:0] core_rsp_rdata;
    logic                  core_rsp_ack;

    modport slave (
        input  req_valid, req_rw, req_addr, req_len,
        input  wr_data, wr_data_valid,
        input  core_cmd_ready,
        input  core_rsp_valid, core_rsp_rdata, core_rsp_ack,
        output req_ready, wr_data_ready,
        output rd_data, rd_data_valid,
        output done, nack_err, busy,
        output core_cmd_valid, core_cmd_op,
        output core_cmd_wdata, core_cmd_last
    );

    modport master (
        output req_valid, req_rw, req_addr, req_len,
        output wr_data, wr_data_valid,
        output core_cmd_ready,
        output core_rsp_valid, core_rsp_rdata, core_rsp_ack,
        input  req_ready, wr_data_ready,
        input  rd_data, rd_data_valid,
        input  done, nack_err, busy,
        input  core_cmd_valid, core_cmd_op,
        input  core_cmd_wdata, core_cmd_last
    );

endinterface

// File: rtl/i2c_txn_sequencer.sv
// Sequences START, address, data bytes and STOP into the I2C byte engine
// for one request at a time.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input logic                clk,
    input logic                reset_n,
    i2c_txn_sequencer_if.slave bus_if
);

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    i2c_state_e            state_q, state_d;
    logic                  wait_q, wait_d;
    logic                  rw_q, rw_d;
    logic [6:0]            addr_q, addr_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  nack_q, nack_d;
    logic [I2C_BYTE_W-1:0] wbyte_q, wbyte_d;
    logic                  whave_q, whave_d;
    logic [I2C_BYTE_W-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic                  req_rdy;
    logic                  wr_rdy;
    logic                  cmd_vld;
    i2c_op_t               cmd_op;
    logic [I2C_BYTE_W-1:0] cmd_wdata;
    logic                  cmd_last;
    logic                  rsp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wait_q   <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            nack_q   <= 1'b0;
            wbyte_q  <= '0;
            whave_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            nack_q   <= nack_d;
            wbyte_q  <= wbyte_d;
            whave_q  <= whave_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        nack_d    = nack_q;
        wbyte_d   = wbyte_q;
        whave_d   = whave_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        req_rdy   = 1'b0;
        wr_rdy    = 1'b0;
        cmd_vld   = 1'b0;
        cmd_op    = I2C_OP_START;
        cmd_wdata = '0;
        cmd_last  = 1'b0;
        // responses only count while a command is outstanding
        rsp       = wait_q && bus_if.core_rsp_valid;

        unique case (state_q)
            ST_IDLE: begin
                req_rdy = 1'b1;
                if (bus_if.req_valid) begin
                    rw_d    = bus_if.req_rw;
                    addr_d  = bus_if.req_addr;
                    cnt_d   = bus_if.req_len;
                    nack_d  = 1'b0;
                    wait_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cmd_op  = I2C_OP_START;
                cmd_vld = !wait_q;
                if (rsp) begin
                    wait_d  = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cmd_op    = I2C_OP_WRITE;
                cmd_wdata = {addr_q, rw_q};
                cmd_vld   = !wait_q;
                if (rsp) begin
                    wait_d = 1'b0;
                    if (!bus_if.core_rsp_ack) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (cnt_q == '0) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = rw_q ? ST_RDATA : ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                cmd_op    = I2C_OP_WRITE;
                cmd_wdata = wbyte_q;
                cmd_vld   = !wait_q && whave_q;
                wr_rdy    = !wait_q && !whave_q;
                if (wr_rdy && bus_if.wr_data_valid) begin
                    wbyte_d = bus_if.wr_data;
                    whave_d = 1'b1;
                end
                if (rsp) begin
                    wait_d = 1'b0;
                    if (!bus_if.core_rsp_ack) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end
            ST_RDATA: begin
                cmd_op   = I2C_OP_READ;
                cmd_last = (cnt_q == CNT_ONE);
                cmd_vld  = !wait_q;
                if (rsp) begin
                    wait_d   = 1'b0;
                    rdata_d  = bus_if.core_rsp_rdata;
                    rvalid_d = 1'b1;
                    cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                cmd_op  = I2C_OP_STOP;
                cmd_vld = !wait_q;
                if (rsp) begin
                    wait_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // accepted command: move to await and release the held write byte
        if (cmd_vld && bus_if.core_cmd_ready) begin
            wait_d  = 1'b1;
            whave_d = 1'b0;
        end
    end

    assign bus_if.req_ready      = req_rdy;
    assign bus_if.wr_data_ready  = wr_rdy;
    assign bus_if.rd_data        = rdata_q;
    assign bus_if.rd_data_valid  = rvalid_q;
    assign bus_if.done           = (state_q == ST_DONE);
    assign bus_if.nack_err       = nack_q;
    assign bus_if.busy           = (state_q != ST_IDLE) &&
                                   (state_q != ST_DONE);
    assign bus_if.core_cmd_valid = cmd_vld;
    assign bus_if.core_cmd_op    = cmd_op;
    assign bus_if.core_cmd_wdata = cmd_wdata;
    assign bus_if.core_cmd_last  = cmd_last;

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Transaction-level controller that sequences the I2C byte/bit engine for a single-master bus. Accepts one request (7-bit slave address, direction, byte count) and issues the ordered command stream to the engine: START, address byte, N data bytes, STOP. Sits between the Avalon slave register file and the I2C core. Streams write bytes in, streams read bytes out, and reports completion and NACK status.

Parameters:
LEN_W, 8, width of the byte-count field; a request carries 0 to 2^LEN_W-1 data bytes.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_rw  in  1  1 = read, 0 = write
req_addr  in  7  slave address
req_len  in  LEN_W  data byte count; 0 = address-only probe
wr_data  in  8  next write byte
wr_data_valid  in  1  wr_data present
wr_data_ready  out  1  byte consumed when valid && ready
rd_data  out  8  received byte
rd_data_valid  out  1  one-cycle pulse per received byte
done  out  1  one-cycle pulse at transaction end
nack_err  out  1  slave NACKed address or write byte; valid with done
busy  out  1  high from request accept until done
core_cmd_valid  out  1  command to engine
core_cmd_ready  in  1  engine accepts command
core_cmd_op  out  2  START=0, WRITE=1, READ=2, STOP=3
core_cmd_wdata  out  8  byte for WRITE
core_cmd_last  out  1  on READ: master NACKs this byte
core_rsp_valid  in  1  one-cycle pulse: command finished
core_rsp_rdata  in  8  byte from READ
core_rsp_ack  in  1  slave ACK seen for START/WRITE

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: every output is 0, except req_ready = 1. State = IDLE. Internal registers (latched request, byte counter, wait phase) are cleared.
- Reset mid-transaction: everything clears immediately and core_cmd_valid drops. The engine shares reset_n, so no STOP is issued.
- States: IDLE, START, ADDR, WDATA, RDATA, STOP, DONE. Every command state has two phases: issue (core_cmd_valid high) and await (core_cmd_valid low, waiting for core_rsp_valid).
- IDLE:
  - req_ready = 1 only in IDLE.
  - On accept, latch req_rw, req_addr and req_len into cnt, clear nack_err, set busy, go to START the next cycle.
- Command handshake:
  - core_cmd_valid, op, wdata and last stay stable until core_cmd_ready.
  - The cycle after acceptance enters await.
  - core_rsp_valid is ignored outside await.
- START and ADDR:
  - START issues op 0.
  - ADDR issues WRITE with wdata = {addr, rw}.
  - If core_rsp_ack = 0 after ADDR: set nack_err, go to STOP.
  - Otherwise, if cnt == 0 go to STOP; else go to WDATA (rw = 0) or RDATA (rw = 1).
- WDATA:
  - wr_data_ready = 1 while in issue phase and no byte is yet held.
  - The captured byte drives core_cmd_wdata the next cycle.
  - After the response: on NACK, set nack_err and go to STOP. On ACK, decrement cnt; go to STOP if cnt reaches 0, else repeat WDATA.
- RDATA:
  - Issue READ with core_cmd_last = (cnt == 1).
  - On response, rd_data = core_rsp_rdata and rd_data_valid pulses on the cycle after core_rsp_valid. There is no backpressure on the read stream.
  - core_rsp_ack is ignored.
  - Decrement cnt; go to STOP at 0, else repeat RDATA.
- STOP: issue op 3; after the response go to DONE.
- DONE:
  - done pulses for one cycle, busy drops, nack_err holds until the next accept.
  - Return to IDLE; req_ready rises the following cycle.
- Counting: cnt is LEN_W bits, decrements only, and never wraps.
- Simultaneous events: req_valid while busy is ignored. A wr_data_valid outside WDATA issue is not consumed.

Decomposition:
- Shared package i2c_pkg holds:
  - op-code constants I2C_OP_START/WRITE/READ/STOP (2-bit);
  - the state encoding for this FSM;
  - the byte width constant (8).
- No sub-module. The block is a single FSM plus counter and capture registers. The I2C clock divider and the bit engine remain in the I2C core.

Test Plan:
1. Write: addr 0x50, rw 0, len 2, bytes 0xA5, 0x3C; engine ACKs all. Required: commands START, WRITE 0xA0, WRITE 0xA5, WRITE 0x3C, STOP; done with nack_err = 0; wr_data_ready handshakes exactly 2 times.
2. Read: addr 0x68, rw 1, len 3; engine returns 0x11, 0x22, 0x33. Required: WRITE 0xD1 followed by 3 READs with last = 0, 0, 1; three rd_data_valid pulses carrying 0x11, 0x22, 0x33; then STOP and done.
3. Address NACK: addr 0x20, len 4, core_rsp_ack = 0 on the address byte. Required: STOP immediately after the address byte; no WDATA; done with nack_err = 1; wr_data_ready never asserts.
4. Probe: len 0, address ACK. Required: exactly START, WRITE, STOP; done with nack_err = 0.
5. Backpressure/reset: core_cmd_ready held low 5 cycles. Required: cmd fields stable throughout. Then assert reset_n = 0 during RDATA. Required: all outputs return to reset values asynchronously; after release, req_ready = 1 and a new request completes normally.
